// File: rtl/bus_txn_controller.sv
// Control-side sequencer for the shared 8-bit endpoint bus: issues a header,
// counts payload beats from the source endpoint, and ends each transfer with ack.
module bus_txn_controller #(
  parameter int unsigned TIMEOUT = 64,
  parameter logic [1:0]  CTRL_ID = 2'b11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_src,
  input  logic [1:0] cmd_dest,
  input  logic [7:0] cmd_len,
  inout  wire  [7:0] bus_data,
  inout  wire        bus_valid,
  output logic       ack,
  output logic       done,
  output logic       timeout_err,
  output logic [7:0] beat_count
);

  localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_XFER   = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [1:0]        src_q, src_d;
  logic [1:0]        dest_q, dest_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        beat_d;
  logic [IDLE_W-1:0] idle_cnt, idle_d;
  logic              abort_q, abort_d;
  logic              ready_d, ack_d, terr_d;

  // The block only owns the bus during the single HEADER cycle.
  assign bus_valid = (state == ST_HEADER) ? 1'b1 : 1'bz;
  assign bus_data  = (state == ST_HEADER) ? {2'b00, dest_q, src_q, CTRL_ID} : 8'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      src_q       <= 2'd0;
      dest_q      <= 2'd0;
      len_q       <= 8'd0;
      beat_count  <= 8'd0;
      idle_cnt    <= '0;
      abort_q     <= 1'b0;
      cmd_ready   <= 1'b1;
      ack         <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      src_q       <= src_d;
      dest_q      <= dest_d;
      len_q       <= len_d;
      beat_count  <= beat_d;
      idle_cnt    <= idle_d;
      abort_q     <= abort_d;
      cmd_ready   <= ready_d;
      ack         <= ack_d;
      done        <= ack_d;
      timeout_err <= terr_d;
    end
  end

  always_comb begin
    state_d = state;
    src_d   = src_q;
    dest_d  = dest_q;
    len_d   = len_q;
    beat_d  = beat_count;
    idle_d  = idle_cnt;
    abort_d = abort_q;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          src_d   = cmd_src;
          dest_d  = cmd_dest;
          len_d   = cmd_len;
          beat_d  = 8'd0;
          idle_d  = '0;
          abort_d = 1'b0;
          state_d = ST_HEADER;
        end
      end
      ST_HEADER: state_d = (len_q == 8'd0) ? ST_ACK : ST_XFER;
      ST_XFER: begin
        // Only a clean 1 is a beat; 0, z and x all count toward the watchdog.
        if (bus_valid == 1'b1) begin
          beat_d = beat_count + 8'd1;
          idle_d = '0;
          if (beat_count + 8'd1 == len_q) state_d = ST_ACK;
        end else if (idle_cnt == IDLE_MAX) begin
          abort_d = 1'b1;
          state_d = ST_ACK;
        end else begin
          idle_d = idle_cnt + IDLE_W'(1);
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    ack_d   = (state_d == ST_ACK);
    terr_d  = (state_d == ST_ACK) && abort_d;
  end

endmodule

// File: tb/tb_bus_txn_controller.sv
// Randomized self-checking bench for bus_txn_controller; expected timing is
// derived per transaction from a beat-gap schedule.
module tb_bus_txn_controller;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_src, cmd_dest;
  logic [7:0] cmd_len;
  wire  [7:0] bus_data;
  wire        bus_valid;
  logic       ack, done, timeout_err;
  logic [7:0] beat_count;

  logic       tb_v_en, tb_v, tb_d_en;
  logic [7:0] tb_d;

  int compares = 0;
  int fails    = 0;
  int gaps [0:255];

  assign bus_valid = tb_v_en ? tb_v : 1'bz;
  assign bus_data  = tb_d_en ? tb_d : 8'bz;

  always #5 clk = ~clk;

  bus_txn_controller #(.TIMEOUT(TO), .CTRL_ID(2'b11)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dest(cmd_dest), .cmd_len(cmd_len),
    .bus_data(bus_data), .bus_valid(bus_valid),
    .ack(ack), .done(done), .timeout_err(timeout_err),
    .beat_count(beat_count)
  );

  task automatic release_bus();
    tb_v_en = 1'b0; tb_v = 1'b0; tb_d_en = 1'b0; tb_d = 8'h00;
  endtask

  // One full transaction: expected ack edge, abort flag and beat edges are
  // computed up front from the gap schedule, then checked every cycle.
  task automatic run_txn(input string name, input logic [1:0] src, input logic [1:0] dest,
                         input logic [7:0] len, input int nbeats, input bit hold,
                         input logic [1:0] nsrc, input logic [1:0] ndest, input logic [7:0] nlen);
    bit         beat_at [0:4095];
    int         ack_t, prev, bc;
    bit         abort, exp_ack;
    logic [7:0] hdr;
    for (int i = 0; i < 4096; i++) beat_at[i] = 1'b0;
    abort = 1'b0;
    hdr   = {2'b00, dest, src, 2'b11};
    if (len == 8'd0) ack_t = 1;
    else begin
      prev  = 1;
      ack_t = -1;
      for (int i = 0; i < int'(len) && ack_t < 0; i++) begin
        if (i < nbeats && gaps[i] < TO) begin
          prev = prev + gaps[i] + 1;
          beat_at[prev] = 1'b1;
          if (i + 1 == int'(len)) ack_t = prev;
        end else begin
          abort = 1'b1;
          ack_t = prev + TO;
        end
      end
    end

    compares++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL %s/ready_before_accept: got %b expected 1", name, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_src = src; cmd_dest = dest; cmd_len = len;
    @(posedge clk); #1;
    if (hold) begin
      cmd_valid = 1'b1; cmd_src = nsrc; cmd_dest = ndest; cmd_len = nlen;
    end else begin
      cmd_valid = 1'b0; cmd_src = 2'($urandom); cmd_dest = 2'($urandom); cmd_len = 8'($urandom);
    end

    bc = 0;
    for (int t = 0; t <= ack_t + 1; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      if (t > 0 && beat_at[t]) bc++;
      exp_ack = (t == ack_t);
      if (t == 0) begin
        compares++;
        if (bus_valid !== 1'b1 || bus_data !== hdr) begin
          fails++; $display("FAIL %s/header: got valid=%b data=%h expected valid=1 data=%h",
                            name, bus_valid, bus_data, hdr);
        end
      end else if (!tb_v_en) begin
        compares++;
        if (bus_valid === 1'b1) begin
          fails++; $display("FAIL %s/bus_release t=%0d: got valid=%b expected released", name, t, bus_valid);
        end
      end
      if (tb_d_en) begin
        compares++;
        if (bus_data !== tb_d) begin
          fails++; $display("FAIL %s/payload t=%0d: got %h expected %h", name, t, bus_data, tb_d);
        end
      end
      compares++;
      if (beat_count !== 8'(bc)) begin
        fails++; $display("FAIL %s/beat_count t=%0d: got %0d expected %0d", name, t, beat_count, bc);
      end
      compares++;
      if (ack !== exp_ack || done !== exp_ack) begin
        fails++; $display("FAIL %s/ack_done t=%0d: got ack=%b done=%b expected %b", name, t, ack, done, exp_ack);
      end
      compares++;
      if (timeout_err !== (exp_ack && abort)) begin
        fails++; $display("FAIL %s/timeout_err t=%0d: got %b expected %b", name, t, timeout_err, exp_ack && abort);
      end
      compares++;
      if (cmd_ready !== (t == ack_t + 1)) begin
        fails++; $display("FAIL %s/cmd_ready t=%0d: got %b expected %b", name, t, cmd_ready, t == ack_t + 1);
      end
      // Drive the value the DUT samples at edge t+1.
      release_bus();
      if (t > 0 && t < ack_t) begin
        if (beat_at[t + 1]) begin
          tb_v_en = 1'b1; tb_v = 1'b1; tb_d_en = 1'b1; tb_d = 8'($urandom);
        end else if ($urandom_range(0, 1) == 1) begin
          tb_v_en = 1'b1; tb_v = 1'b0;
        end
      end
    end
    release_bus();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compares++;
    if (cmd_ready !== 1'b1 || ack !== 1'b0 || done !== 1'b0 || timeout_err !== 1'b0) begin
      fails++; $display("FAIL reset/ctrl: got ready=%b ack=%b done=%b terr=%b expected 1 0 0 0",
                        cmd_ready, ack, done, timeout_err);
    end
    compares++;
    if (beat_count !== 8'd0) begin
      fails++; $display("FAIL reset/beat_count: got %0d expected 0", beat_count);
    end
    compares++;
    if (bus_valid === 1'b1) begin
      fails++; $display("FAIL reset/bus_valid: got %b expected released", bus_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_normal();
    gaps[0] = 1; gaps[1] = 0; gaps[2] = 2; gaps[3] = 1;
    run_txn("normal", 2'd1, 2'd2, 8'd4, 4, 1'b0, 2'd0, 2'd0, 8'd0);
  endtask

  task automatic test_zero_len();
    run_txn("zero_len", 2'd2, 2'd0, 8'd0, 0, 1'b0, 2'd0, 2'd0, 8'd0);
  endtask

  task automatic test_watchdog();
    gaps[0] = 0;
    run_txn("watchdog", 2'd0, 2'd1, 8'd3, 1, 1'b0, 2'd0, 2'd0, 8'd0);
    run_txn("watchdog_nobeat", 2'd3, 2'd3, 8'd2, 0, 1'b0, 2'd0, 2'd0, 8'd0);
    gaps[0] = TO - 1; gaps[1] = TO - 1;
    run_txn("gap_below_limit", 2'd1, 2'd3, 8'd2, 2, 1'b0, 2'd0, 2'd0, 8'd0);
    gaps[0] = 2; gaps[1] = TO;
    run_txn("gap_at_limit", 2'd2, 2'd1, 8'd2, 2, 1'b0, 2'd0, 2'd0, 8'd0);
  endtask

  task automatic test_back_to_back();
    gaps[0] = 3; gaps[1] = 1; gaps[2] = 0;
    run_txn("b2b_first", 2'd1, 2'd0, 8'd3, 3, 1'b1, 2'd2, 2'd3, 8'd1);
    gaps[0] = 0;
    run_txn("b2b_second", 2'd2, 2'd3, 8'd1, 1, 1'b0, 2'd0, 2'd0, 8'd0);
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_src = 2'd3; cmd_dest = 2'd1; cmd_len = 8'd5;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1; tb_v_en = 1'b1; tb_v = 1'b1;
    @(posedge clk); #1; tb_v = 1'b0;
    @(posedge clk); #1; tb_v = 1'b1;
    @(posedge clk); #1; release_bus();
    compares++;
    if (beat_count !== 8'd2) begin
      fails++; $display("FAIL reset_mid/pre_count: got %0d expected 2", beat_count);
    end
    #2 rst_n = 1'b0;
    #1;
    compares++;
    if (cmd_ready !== 1'b1 || ack !== 1'b0 || done !== 1'b0 || timeout_err !== 1'b0 || beat_count !== 8'd0) begin
      fails++; $display("FAIL reset_mid/async: got ready=%b ack=%b done=%b terr=%b count=%0d expected 1 0 0 0 0",
                        cmd_ready, ack, done, timeout_err, beat_count);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      compares++;
      if (ack !== 1'b0 || done !== 1'b0) begin
        fails++; $display("FAIL reset_mid/no_ack: got ack=%b done=%b expected 0 0", ack, done);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    // Reset landing in the header cycle must release the bus immediately.
    cmd_valid = 1'b1; cmd_src = 2'd0; cmd_dest = 2'd2; cmd_len = 8'd1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    compares++;
    if (bus_valid === 1'b1 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL reset_hdr/release: got valid=%b ready=%b expected released 1", bus_valid, cmd_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    gaps[0] = 1; gaps[1] = 0; gaps[2] = 2; gaps[3] = 0; gaps[4] = 1;
    run_txn("post_reset", 2'd3, 2'd1, 8'd5, 5, 1'b0, 2'd0, 2'd0, 8'd0);
  endtask

  task automatic test_long();
    for (int i = 0; i < 256; i++) gaps[i] = 0;
    run_txn("len255", 2'd0, 2'd3, 8'd255, 255, 1'b0, 2'd0, 2'd0, 8'd0);
  endtask

  task automatic test_random();
    logic [1:0] s, d, ns, nd;
    logic [7:0] l, nl;
    int         nb;
    bit         hold;
    ns = 2'($urandom); nd = 2'($urandom); nl = 8'($urandom_range(0, 10));
    for (int k = 0; k < 30; k++) begin
      s = ns; d = nd; l = nl;
      ns = 2'($urandom); nd = 2'($urandom); nl = 8'($urandom_range(0, 10));
      hold = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < 256; i++) gaps[i] = $urandom_range(0, 3);
      if ($urandom_range(0, 5) == 0) gaps[$urandom_range(0, 9)] = $urandom_range(TO - 1, TO + 2);
      nb = int'(l);
      if ($urandom_range(0, 5) == 0) nb = $urandom_range(0, int'(l));
      run_txn("random", s, d, l, nb, hold, ns, nd, nl);
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_src = 2'd0; cmd_dest = 2'd0; cmd_len = 8'd0;
    release_bus();
    for (int i = 0; i < 256; i++) gaps[i] = 0;
    test_reset();
    test_normal();
    test_zero_len();
    test_watchdog();
    test_back_to_back();
    test_reset_mid();
    test_long();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
